// File: rtl/aes_pkg.sv
// Shared AES definitions: column count, FSM encoding and GF(2^8) helpers.
package aes_pkg;

    localparam int         NB       = 4;
    localparam logic [1:0] LAST_COL = 2'(NB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (covers 1, 2, 3, 9, B, D, E) via shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = b;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) begin
                p = p ^ a;
            end
            a = xtime(a);
        end
        return p;
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column.
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] iCol,
    input  logic        iInv,
    output logic [31:0] oCol
);

    logic [7:0] s    [4];
    logic [3:0] coef [4];
    logic [7:0] r    [4];

    // Row i uses the coefficient row rotated right by i: r[i] = sum_j coef[(j-i) mod 4] * s[j].
    always_comb begin
        s[0] = iCol[31:24];
        s[1] = iCol[23:16];
        s[2] = iCol[15:8];
        s[3] = iCol[7:0];
        if (iInv) begin
            coef[0] = 4'hE;
            coef[1] = 4'hB;
            coef[2] = 4'hD;
            coef[3] = 4'h9;
        end else begin
            coef[0] = 4'h2;
            coef[1] = 4'h3;
            coef[2] = 4'h1;
            coef[3] = 4'h1;
        end
        for (int i = 0; i < 4; i++) begin
            r[i] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                r[i] = r[i] ^ gf_mul(s[j], coef[2'(j - i + 4)]);
            end
        end
        oCol = {r[0], r[1], r[2], r[3]};
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns stage: one column per clock, valid/ready on both sides.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a state from ShiftRows, oReady = 1
// BUSY    | transforming column col_q of the working register
// DONE    | result held on oData with oValid = 1 until iReady
module mix_columns_seq
    import aes_pkg::*;
(
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iValid,
    output logic         oReady,
    input  logic [127:0] iData,
    input  logic         iInv,
    input  logic         iBypass,
    output logic         oValid,
    input  logic         iReady,
    output logic [127:0] oData
);

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;
    logic         inv_q, inv_d;
    logic         byp_q, byp_d;
    logic         valid_q, valid_d;
    logic         ready_q, ready_d;

    logic [31:0]  col_in;
    logic [31:0]  col_mixed;
    logic [31:0]  col_out;

    // Pick the column under work; column 0 sits in the top word.
    always_comb begin
        col_in = work_q[127:96];
        case (col_q)
            2'd1:    col_in = work_q[95:64];
            2'd2:    col_in = work_q[63:32];
            2'd3:    col_in = work_q[31:0];
            default: col_in = work_q[127:96];
        endcase
    end

    mix_single_column u_mix (
        .iCol (col_in),
        .iInv (inv_q),
        .oCol (col_mixed)
    );

    assign col_out = byp_q ? col_in : col_mixed;

    // Next-state logic; outputs are computed here and registered so they are glitch-free.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        inv_d   = inv_q;
        byp_d   = byp_q;
        valid_d = valid_q;
        ready_d = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    work_d  = iData;
                    inv_d   = iInv;
                    byp_d   = iBypass;
                    col_d   = 2'd0;
                    ready_d = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                case (col_q)
                    2'd1:    work_d[95:64]  = col_out;
                    2'd2:    work_d[63:32]  = col_out;
                    2'd3:    work_d[31:0]   = col_out;
                    default: work_d[127:96] = col_out;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == LAST_COL) begin
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (iReady) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-block discards the partial result.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            col_q   <= 2'd0;
            work_q  <= 128'h0;
            inv_q   <= 1'b0;
            byp_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            inv_q   <= inv_d;
            byp_q   <= byp_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign oValid = valid_q;
    assign oReady = ready_q;
    assign oData  = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed self-checking bench for mix_columns_seq.
module tb_mix_columns_seq;

    logic         iClk;
    logic         iRst_n;
    logic         iValid;
    logic         oReady;
    logic [127:0] iData;
    logic         iInv;
    logic         iBypass;
    logic         oValid;
    logic         iReady;
    logic [127:0] oData;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] V_PLAIN = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V_MIXED = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] V_BYP   = 128'h8233ea63fcac161bee28c3c4c193f54b;

    mix_columns_seq dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iValid  (iValid),
        .oReady  (oReady),
        .iData   (iData),
        .iInv    (iInv),
        .iBypass (iBypass),
        .oValid  (oValid),
        .iReady  (iReady),
        .oData   (oData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Drives one state in and waits for the result; caller sits #1 after a rising edge.
    task automatic do_xfer(input logic [127:0] d, input logic inv, input logic byp,
                           output logic [127:0] res, output int lat, output int vlen);
        int n;
        n = 0;
        while (!oReady && n < 20) begin
            @(posedge iClk); #1;
            n++;
        end
        iData   = d;
        iInv    = inv;
        iBypass = byp;
        iValid  = 1'b1;
        @(posedge iClk); #1;
        iValid  = 1'b0;
        lat = 0;
        while (!oValid && lat < 20) begin
            @(posedge iClk); #1;
            lat++;
        end
        res  = oData;
        vlen = 0;
        while (oValid && vlen < 20) begin
            @(posedge iClk); #1;
            vlen++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge iClk);
        #1;
        total++;
        if (oValid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b exp=0", oValid); end
        total++;
        if (oReady !== 1'b1) begin bad++; $display("FAIL reset_oready got=%b exp=1", oReady); end
        total++;
        if (oData !== 128'h0) begin bad++; $display("FAIL reset_odata got=%h exp=0", oData); end
        iRst_n = 1'b1;
        @(posedge iClk); #1;
        total++;
        if (oReady !== 1'b1) begin bad++; $display("FAIL idle_oready got=%b exp=1", oReady); end
    endtask

    task automatic test_forward();
        logic [127:0] res;
        int lat, vlen;
        iReady = 1'b1;
        do_xfer(V_PLAIN, 1'b0, 1'b0, res, lat, vlen);
        total++;
        if (res !== V_MIXED) begin bad++; $display("FAIL fwd_data got=%h exp=%h", res, V_MIXED); end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL fwd_latency got=%0d exp=4", lat); end
        total++;
        if (vlen !== 1) begin bad++; $display("FAIL fwd_valid_len got=%0d exp=1", vlen); end
        total++;
        if (oReady !== 1'b1) begin bad++; $display("FAIL fwd_ready_after got=%b exp=1", oReady); end
    endtask

    task automatic test_inverse();
        logic [127:0] res;
        int lat, vlen;
        iReady = 1'b1;
        do_xfer(V_MIXED, 1'b1, 1'b0, res, lat, vlen);
        total++;
        if (res !== V_PLAIN) begin bad++; $display("FAIL inv_data got=%h exp=%h", res, V_PLAIN); end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL inv_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_bypass();
        logic [127:0] res;
        int lat, vlen;
        iReady = 1'b1;
        do_xfer(V_BYP, 1'b0, 1'b1, res, lat, vlen);
        total++;
        if (res !== V_BYP) begin bad++; $display("FAIL byp_data got=%h exp=%h", res, V_BYP); end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL byp_latency got=%0d exp=4", lat); end
        total++;
        if (vlen !== 1) begin bad++; $display("FAIL byp_valid_len got=%0d exp=1", vlen); end
    endtask

    task automatic test_backpressure();
        int n;
        iReady  = 1'b0;
        iData   = V_PLAIN;
        iInv    = 1'b0;
        iBypass = 1'b0;
        iValid  = 1'b1;
        @(posedge iClk); #1;
        iValid = 1'b0;
        n = 0;
        while (!oValid && n < 20) begin
            @(posedge iClk); #1;
            n++;
        end
        total++;
        if (n !== 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", n); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (oValid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, oValid); end
            total++;
            if (oData !== V_MIXED) begin bad++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, oData, V_MIXED); end
            total++;
            if (oReady !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, oReady); end
            if (i == 2) begin
                iData  = V_BYP;
                iInv   = 1'b1;
                iValid = 1'b1;
            end
            @(posedge iClk); #1;
        end
        iValid = 1'b0;
        iReady = 1'b1;
        @(posedge iClk); #1;
        total++;
        if (oReady !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", oReady); end
        total++;
        if (oValid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", oValid); end
        total++;
        if (oData !== V_MIXED) begin bad++; $display("FAIL bp_release_data got=%h exp=%h", oData, V_MIXED); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int lat, vlen;
        logic seen;
        iReady  = 1'b1;
        iData   = V_PLAIN;
        iInv    = 1'b0;
        iBypass = 1'b0;
        iValid  = 1'b1;
        @(posedge iClk); #1;
        iValid = 1'b0;
        @(posedge iClk); #1;
        iRst_n = 1'b0;
        @(posedge iClk); #1;
        iRst_n = 1'b1;
        total++;
        if (oValid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", oValid); end
        total++;
        if (oReady !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", oReady); end
        total++;
        if (oData !== 128'h0) begin bad++; $display("FAIL mid_rst_data got=%h exp=0", oData); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge iClk); #1;
            if (oValid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_stray_valid got=%b exp=0", seen); end
        do_xfer(V_PLAIN, 1'b0, 1'b0, res, lat, vlen);
        total++;
        if (res !== V_MIXED) begin bad++; $display("FAIL mid_rst_after_data got=%h exp=%h", res, V_MIXED); end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL mid_rst_after_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vd  [3];
        logic         vi  [3];
        logic         vb  [3];
        logic [127:0] ex  [3];
        logic [127:0] got [3];
        int           acc [3];
        int n_acc, n_got, cyc;
        logic extra;
        vd[0] = V_PLAIN; vi[0] = 1'b0; vb[0] = 1'b0; ex[0] = V_MIXED;
        vd[1] = V_MIXED; vi[1] = 1'b1; vb[1] = 1'b0; ex[1] = V_PLAIN;
        vd[2] = V_BYP;   vi[2] = 1'b0; vb[2] = 1'b1; ex[2] = V_BYP;
        for (int i = 0; i < 3; i++) begin
            got[i] = 128'hx;
            acc[i] = -100;
        end
        n_acc  = 0;
        n_got  = 0;
        cyc    = 0;
        iReady = 1'b1;
        while (n_got < 3 && cyc < 100) begin
            if (oValid === 1'b1) begin
                got[n_got] = oData;
                n_got++;
            end
            if (oReady === 1'b1 && n_acc < 3) begin
                iData   = vd[n_acc];
                iInv    = vi[n_acc];
                iBypass = vb[n_acc];
                iValid  = 1'b1;
                acc[n_acc] = cyc + 1;
                n_acc++;
            end else if (n_acc == 3 && oReady === 1'b0) begin
                iValid = 1'b0;
            end
            @(posedge iClk); #1;
            cyc++;
        end
        iValid = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (oValid === 1'b1) extra = 1'b1;
            @(posedge iClk); #1;
        end
        total++;
        if (n_got !== 3) begin bad++; $display("FAIL b2b_result_count got=%0d exp=3", n_got); end
        total++;
        if (n_acc !== 3) begin bad++; $display("FAIL b2b_accept_count got=%0d exp=3", n_acc); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got[i] !== ex[i]) begin bad++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", i, got[i], ex[i]); end
        end
        total++;
        if (acc[1] - acc[0] !== 6) begin bad++; $display("FAIL b2b_spacing01 got=%0d exp=6", acc[1] - acc[0]); end
        total++;
        if (acc[2] - acc[1] !== 6) begin bad++; $display("FAIL b2b_spacing12 got=%0d exp=6", acc[2] - acc[1]); end
        total++;
        if (extra !== 1'b0) begin bad++; $display("FAIL b2b_duplicate got=%b exp=0", extra); end
    endtask

    initial begin
        iRst_n  = 1'b0;
        iValid  = 1'b0;
        iData   = 128'h0;
        iInv    = 1'b0;
        iBypass = 1'b0;
        iReady  = 1'b1;
        test_reset();
        test_forward();
        test_inverse();
        test_bypass();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Sequential AES MixColumns stage, directly downstream of ShiftRows in the DE10 AES datapath.
- Accepts one 128-bit state over a valid/ready handshake and processes one 32-bit column per clock.
- Supports forward MixColumns, InvMixColumns, and a bypass for the final round, where MixColumns is skipped.
- Presents the result with a valid/ready handshake to AddRoundKey.

Parameters:
- None. Block size is fixed at 128 bits and 4 columns.

Ports:
- iClk     input   1    clock; all logic on the rising edge
- iRst_n   input   1    synchronous active-low reset
- iValid   input   1    iData/iInv/iBypass are valid
- oReady   output  1    block can accept a new state
- iData    input   128  state from ShiftRows; byte 0 = bits[127:120], column c = bits[127-32c -: 32]
- iInv     input   1    1 = InvMixColumns, 0 = MixColumns
- iBypass  input   1    1 = pass the state through unchanged (final round)
- oValid   output  1    oData holds a completed state
- iReady   input   1    downstream accepts oData
- oData    output  128  transformed state, same byte ordering as iData

Behaviour:
- Reset: sampled on the iClk edge while iRst_n=0.
  - State goes to IDLE; column counter = 0.
  - oValid = 0, oReady = 1 (IDLE), oData = 128'h0.
  - Reset mid-operation aborts the block; the partial result is discarded and no oValid is produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - oReady = 1.
  - On iValid=1 at an edge (accept): latch iData into the working register; latch iInv and iBypass; counter = 0; go to BUSY.
- BUSY:
  - oReady = 0, oValid = 0.
  - Each edge replaces column[counter] of the working register with mix(column), invmix(column), or the unchanged column (bypass).
  - Counter increments; on the edge that processes column 3, go to DONE.
  - iData, iInv, iBypass and iValid are ignored while BUSY.
- DONE:
  - oValid = 1; oData = working register, held stable.
  - oReady = 0.
  - On iReady=1 at an edge: go to IDLE, oValid drops.
  - iReady=0 stalls indefinitely with oData unchanged.
- Latency: accept at edge k; columns processed at edges k+1..k+4; oValid=1 after edge k+4.
  - Minimum accept-to-accept spacing is 6 cycles (DONE consumed at k+5, IDLE at k+6).
- Bypass takes the same 4-cycle latency as a real transform.
- iValid asserted with iReady already high during DONE: the DONE->IDLE transition comes first; the new state is accepted only in IDLE.
- oData is driven only from the working register; no combinational path from iData to oData.
- Arithmetic is in GF(2^8), polynomial 0x11B.
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
  - Forward column s0..s3: r0 = 2s0^3s1^s2^s3, then rotate the coefficients for r1..r3.
  - Inverse: coefficients 0E,0B,0D,09 in the same rotation.
  - All results are 8-bit exact; no carries or overflow.

Decomposition:
- Shared package (aes_pkg):
  - xtime function and gf_mul function (multiplier constants 2, 3, 9, B, D, E);
  - localparam NB = 4 (columns);
  - FSM state encoding for IDLE/BUSY/DONE.
- One combinational sub-module, mix_single_column: 32-bit in, iInv, 32-bit out.
  - Single instance in this block, muxed by the column counter.
- The FSM and working register live in mix_columns_seq.

Test Plan:
- FIPS-197 vector: iData=128'hd4bf5d30e0b452aeb84111f11e2798e5, iInv=0, iBypass=0, iReady=1.
  - Required: oData=128'h046681e5e0cb199a48f8d37a2806264c.
  - oValid rises exactly 4 cycles after the accept edge and lasts 1 cycle.
- Inverse: iData=128'h046681e5e0cb199a48f8d37a2806264c, iInv=1.
  - Required: oData=128'hd4bf5d30e0b452aeb84111f11e2798e5.
- Bypass: iData=128'h8233ea63fcac161bee28c3c4c193f54b, iBypass=1.
  - Required: oData equals the input; latency is identical to the forward case.
- Backpressure: hold iReady=0 for 10 cycles after oValid.
  - oValid and oData stay stable; oReady stays 0.
  - A new iValid with different iData is ignored.
  - Releasing iReady returns the block to IDLE with oReady=1 the next cycle.
- Reset mid-operation: drive iRst_n=0 for one edge two cycles after accept.
  - Next cycle: oValid=0, oReady=1, oData=0.
  - A following forward vector produces the correct result.
- Back-to-back: hold iValid=1 continuously with iReady=1 over 3 distinct vectors.
  - Each result is correct and in order; accepts are spaced 6 cycles apart; no vector is lost or duplicated.
